// File: rtl/gpio_ex.sv
// gpio_ex: memory-mapped GPIO block. Pad inputs are synchronised, optionally
// debounced per pin and fed into edge/level interrupt detection; output data,
// direction and pull enables are driven straight from registers.
module gpio_ex #(
    parameter int          GPIO_WIDTH   = 32,
    parameter int          SYNC_STAGES  = 2,
    parameter int          DBNC_SAMPLES = 4,
    parameter logic [15:0] DBNC_PRE_RST = 16'd999,
    parameter int          XLEN         = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stb_i,
    input  logic [4:0]            adr_i,
    input  logic [3:0]            byte_sel_i,
    input  logic                  we_i,
    input  logic [XLEN-1:0]       dat_i,
    output logic [XLEN-1:0]       dat_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic [GPIO_WIDTH-1:0] gpio_pue_o,
    output logic [GPIO_WIDTH-1:0] gpio_pde_o,
    output logic                  irq_o
);
    localparam int W = GPIO_WIDTH;
    typedef logic [W-1:0] pins_t;

    typedef enum logic [4:0] {
        A_DIR      = 5'h00,
        A_OUT      = 5'h01,
        A_IN       = 5'h02,
        A_SET      = 5'h03,
        A_CLR      = 5'h04,
        A_TGL      = 5'h05,
        A_PUE      = 5'h06,
        A_PDE      = 5'h07,
        A_IE       = 5'h08,
        A_IS       = 5'h09,
        A_IBE      = 5'h0A,
        A_IEV      = 5'h0B,
        A_ILVL     = 5'h0C,
        A_DBE      = 5'h0D,
        A_DBNC_PRE = 5'h0E,
        A_RAW      = 5'h0F,
        A_MSKLO    = 5'h10,
        A_MSKHI    = 5'h11
    } reg_addr_e;

    function automatic pins_t lane_merge(input pins_t old_v, input pins_t new_v, input pins_t mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    reg_addr_e reg_sel;
    logic      wr_en;
    logic [XLEN-1:0] lane_mask;
    pins_t     pin_mask;
    pins_t     pin_data;

    pins_t dir_q, out_q, pue_q, pde_q, ie_q, is_q, ibe_q, iev_q, ilvl_q, dbe_q;
    logic [15:0] dbnc_pre_q;
    logic [15:0] pre_cnt_q;
    logic        tick;

    logic [SYNC_STAGES-1:0][W-1:0]  sync_q;
    logic [W-1:0][DBNC_SAMPLES-1:0] hist_q;
    pins_t raw, filt_q, in_w, prev_q;
    pins_t rise, fall, any_edge, trig, is_clr;
    logic [XLEN-1:0] out_wide;
    pins_t out_next;

    assign reg_sel   = reg_addr_e'(adr_i);
    assign wr_en     = stb_i & we_i;
    assign lane_mask = {{8{byte_sel_i[3]}}, {8{byte_sel_i[2]}}, {8{byte_sel_i[1]}}, {8{byte_sel_i[0]}}};
    assign pin_mask  = lane_mask[W-1:0];
    assign pin_data  = dat_i[W-1:0];

    // Configuration registers with byte-lane merge; DBNC_PRE only has lanes 0/1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_q      <= '0;
            pue_q      <= '0;
            pde_q      <= '0;
            ie_q       <= '0;
            ibe_q      <= '0;
            iev_q      <= '0;
            ilvl_q     <= '0;
            dbe_q      <= '0;
            dbnc_pre_q <= DBNC_PRE_RST;
        end else if (wr_en) begin
            case (reg_sel)
                A_DIR:      dir_q  <= lane_merge(dir_q, pin_data, pin_mask);
                A_PUE:      pue_q  <= lane_merge(pue_q, pin_data, pin_mask);
                A_PDE:      pde_q  <= lane_merge(pde_q, pin_data, pin_mask);
                A_IE:       ie_q   <= lane_merge(ie_q, pin_data, pin_mask);
                A_IBE:      ibe_q  <= lane_merge(ibe_q, pin_data, pin_mask);
                A_IEV:      iev_q  <= lane_merge(iev_q, pin_data, pin_mask);
                A_ILVL:     ilvl_q <= lane_merge(ilvl_q, pin_data, pin_mask);
                A_DBE:      dbe_q  <= lane_merge(dbe_q, pin_data, pin_mask);
                A_DBNC_PRE: dbnc_pre_q <= (dbnc_pre_q & ~lane_mask[15:0]) | (dat_i[15:0] & lane_mask[15:0]);
                default: ;
            endcase
        end
    end

    // Next OUT value: plain, atomic and masked writes, computed full-width so
    // mask bits above GPIO_WIDTH fall away at truncation.
    always_comb begin
        out_wide = XLEN'(out_q);
        if (wr_en) begin
            case (reg_sel)
                A_OUT: out_wide = (out_wide & ~lane_mask) | (dat_i & lane_mask);
                A_SET: out_wide = out_wide | (dat_i & lane_mask);
                A_CLR: out_wide = out_wide & ~(dat_i & lane_mask);
                A_TGL: out_wide = out_wide ^ (dat_i & lane_mask);
                A_MSKLO: begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        if (dat_i[16+i]) out_wide[i] = dat_i[i];
                    end
                end
                A_MSKHI: begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        if (dat_i[16+i]) out_wide[16+i] = dat_i[i];
                    end
                end
                default: ;
            endcase
        end
        out_next = out_wide[W-1:0];
    end

    // Output data register.
    always_ff @(posedge clk_i) begin
        if (rst_i) out_q <= '0;
        else       out_q <= out_next;
    end

    // Debounce prescaler: wraps at DBNC_PRE, restarts on any DBNC_PRE write.
    assign tick = (pre_cnt_q == dbnc_pre_q);
    always_ff @(posedge clk_i) begin
        if (rst_i)                              pre_cnt_q <= '0;
        else if (wr_en && reg_sel == A_DBNC_PRE) pre_cnt_q <= '0;
        else if (tick)                          pre_cnt_q <= '0;
        else                                    pre_cnt_q <= pre_cnt_q + 16'd1;
    end

    // Pad input synchroniser chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
    end
    assign raw = sync_q[SYNC_STAGES-1];

    // Per-pin sample history and hysteretic filter output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            filt_q <= '0;
        end else begin
            for (int unsigned p = 0; p < W; p++) begin
                if (tick) hist_q[p] <= {hist_q[p][DBNC_SAMPLES-2:0], raw[p]};
                if (&hist_q[p])       filt_q[p] <= 1'b1;
                else if (~|hist_q[p]) filt_q[p] <= 1'b0;
            end
        end
    end

    assign in_w     = (dbe_q & filt_q) | (~dbe_q & raw);
    assign rise     = in_w & ~prev_q;
    assign fall     = ~in_w & prev_q;
    assign any_edge = in_w ^ prev_q;
    assign trig     = (ilvl_q & iev_q & in_w) | (ilvl_q & ~iev_q & ~in_w)
                    | (~ilvl_q & ibe_q & any_edge)
                    | (~ilvl_q & ~ibe_q & iev_q & rise)
                    | (~ilvl_q & ~ibe_q & ~iev_q & fall);
    assign is_clr   = (wr_en && reg_sel == A_IS) ? (pin_data & pin_mask) : '0;

    // Previous IN for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= '0;
        else       prev_q <= in_w;
    end

    // Interrupt status: a trigger in the same cycle wins over a W1C clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) is_q <= '0;
        else       is_q <= (is_q & ~is_clr) | trig;
    end

    // Combinational register read mux.
    always_comb begin
        dat_o = '0;
        case (reg_sel)
            A_DIR:                      dat_o = XLEN'(dir_q);
            A_OUT, A_SET, A_CLR, A_TGL: dat_o = XLEN'(out_q);
            A_IN:                       dat_o = XLEN'(in_w);
            A_PUE:                      dat_o = XLEN'(pue_q);
            A_PDE:                      dat_o = XLEN'(pde_q);
            A_IE:                       dat_o = XLEN'(ie_q);
            A_IS:                       dat_o = XLEN'(is_q);
            A_IBE:                      dat_o = XLEN'(ibe_q);
            A_IEV:                      dat_o = XLEN'(iev_q);
            A_ILVL:                     dat_o = XLEN'(ilvl_q);
            A_DBE:                      dat_o = XLEN'(dbe_q);
            A_DBNC_PRE:                 dat_o = XLEN'(dbnc_pre_q);
            A_RAW:                      dat_o = XLEN'(raw);
            default:                    dat_o = '0;
        endcase
    end

    assign gpio_o     = out_q;
    assign gpio_oe_o  = dir_q;
    assign gpio_pue_o = pue_q;
    assign gpio_pde_o = pde_q;
    assign irq_o      = |(is_q & ie_q);
endmodule

// File: tb/tb_gpio_ex.sv
// tb_gpio_ex: randomized and directed checks of gpio_ex against a
// behavioural model of the register map, input path and interrupt rules.
module tb_gpio_ex;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int NW = 12;

    localparam logic [4:0] R_DIR = 5'h00, R_OUT = 5'h01, R_IN = 5'h02, R_SET = 5'h03,
                           R_CLR = 5'h04, R_TGL = 5'h05, R_PUE = 5'h06, R_PDE = 5'h07,
                           R_IE = 5'h08, R_IS = 5'h09, R_IBE = 5'h0A, R_IEV = 5'h0B,
                           R_ILVL = 5'h0C, R_DBE = 5'h0D, R_PRE = 5'h0E, R_RAW = 5'h0F,
                           R_MSKLO = 5'h10, R_MSKHI = 5'h11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb_a = 1'b0, stb_b = 1'b0, we = 1'b0;
    logic [4:0]  adr = '0;
    logic [3:0]  bs = '0;
    logic [31:0] dat = '0;
    logic [31:0] gpio_a = '0;
    logic [NW-1:0] gpio_b = '0;
    logic [31:0] dat_o_a, dat_o_b;
    logic [31:0] go_a, oe_a, pue_a, pde_a;
    logic [NW-1:0] go_b, oe_b, pue_b, pde_b;
    logic        irq_a, irq_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_dir, m_out, m_pue, m_pde, m_ie, m_ibe, m_iev, m_dbe;
    logic [15:0] m_pre;

    gpio_ex #(.GPIO_WIDTH(32), .SYNC_STAGES(S), .DBNC_SAMPLES(D), .DBNC_PRE_RST(16'd999)) dut_a (
        .clk_i(clk), .rst_i(rst), .stb_i(stb_a), .adr_i(adr), .byte_sel_i(bs), .we_i(we),
        .dat_i(dat), .dat_o(dat_o_a), .gpio_i(gpio_a), .gpio_o(go_a), .gpio_oe_o(oe_a),
        .gpio_pue_o(pue_a), .gpio_pde_o(pde_a), .irq_o(irq_a));

    gpio_ex #(.GPIO_WIDTH(NW), .SYNC_STAGES(S), .DBNC_SAMPLES(D), .DBNC_PRE_RST(16'd999)) dut_b (
        .clk_i(clk), .rst_i(rst), .stb_i(stb_b), .adr_i(adr), .byte_sel_i(bs), .we_i(we),
        .dat_i(dat), .dat_o(dat_o_b), .gpio_i(gpio_b), .gpio_o(go_b), .gpio_oe_o(oe_b),
        .gpio_pue_o(pue_b), .gpio_pde_o(pde_b), .irq_o(irq_b));

    always #50 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    task automatic wr(input bit unit, input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        adr = a; dat = d; bs = b; we = 1'b1;
        if (unit) stb_b = 1'b1; else stb_a = 1'b1;
        tick();
        we = 1'b0; stb_a = 1'b0; stb_b = 1'b0;
    endtask

    task automatic rd(input bit unit, input logic [4:0] a, output logic [31:0] d);
        adr = a;
        #1;
        d = unit ? dat_o_b : dat_o_a;
    endtask

    task automatic do_reset();
        gpio_a = '0; gpio_b = '0; stb_a = 1'b0; stb_b = 1'b0; we = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            R_DIR:                      return m_dir;
            R_OUT, R_SET, R_CLR, R_TGL: return m_out;
            R_PUE:                      return m_pue;
            R_PDE:                      return m_pde;
            R_IE:                       return m_ie;
            R_IBE:                      return m_ibe;
            R_IEV:                      return m_iev;
            R_DBE:                      return m_dbe;
            R_PRE:                      return {16'h0, m_pre};
            default:                    return 32'h0;
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] got, exp;
        gpio_a = '0; gpio_b = '0; stb_a = 1'b0; stb_b = 1'b0; we = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        for (int a = 0; a < 32; a++) begin
            exp = (a == 14) ? 32'd999 : 32'd0;
            rd(1'b0, 5'(a), got);
            n_checks++;
            if (got !== exp) $display("FAIL reset_reg[%0h]: got %h expected %h", a, got, exp);
            else n_pass++;
        end
        n_checks++;
        if ({go_a, oe_a, pue_a, pde_a, irq_a} !== '0)
            $display("FAIL reset_outputs: got %h/%h/%h/%h irq %b expected all 0", go_a, oe_a, pue_a, pde_a, irq_a);
        else n_pass++;
        rd(1'b1, R_PRE, got);
        n_checks++;
        if (got !== 32'd999) $display("FAIL reset_b_pre: got %h expected %h", got, 32'd999);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_byte_lanes();
        logic [31:0] got;
        do_reset();
        wr(1'b0, R_OUT, 32'hFFFF0000, 4'b0011);
        rd(1'b0, R_OUT, got);
        n_checks++;
        if (got !== 32'h0) $display("FAIL lanes_out: got %h expected %h", got, 32'h0);
        else n_pass++;
        wr(1'b0, R_MSKLO, 32'h00FF00AA, 4'b0000);
        n_checks++;
        if (go_a !== 32'h000000AA) $display("FAIL lanes_msklo: got %h expected %h", go_a, 32'hAA);
        else n_pass++;
        rd(1'b0, R_MSKLO, got);
        n_checks++;
        if (got !== 32'h0) $display("FAIL lanes_msk_read: got %h expected 0", got);
        else n_pass++;
    endtask

    task automatic test_atomic();
        logic [31:0] got;
        do_reset();
        wr(1'b1, R_SET, 32'hFFFFFFFF, 4'hF);
        rd(1'b1, R_OUT, got);
        n_checks++;
        if (got !== 32'h00000FFF) $display("FAIL atomic_set: got %h expected %h", got, 32'hFFF);
        else n_pass++;
        rd(1'b1, R_TGL, got);
        n_checks++;
        if (got !== 32'h00000FFF) $display("FAIL atomic_tgl_read: got %h expected %h", got, 32'hFFF);
        else n_pass++;
        wr(1'b1, R_TGL, 32'h00000F0F, 4'hF);
        rd(1'b1, R_OUT, got);
        n_checks++;
        if (got !== 32'h000000F0) $display("FAIL atomic_tgl: got %h expected %h", got, 32'hF0);
        else n_pass++;
        wr(1'b1, R_MSKHI, 32'hFFFFFFFF, 4'hF);
        n_checks++;
        if (go_b !== 12'h0F0) $display("FAIL atomic_mskhi_narrow: got %h expected %h", go_b, 12'h0F0);
        else n_pass++;
        wr(1'b1, R_CLR, 32'hFFFFFFFF, 4'b0001);
        n_checks++;
        if ({go_b, oe_b, pue_b, pde_b, irq_b} !== '0)
            $display("FAIL atomic_clr: got %h/%h/%h/%h irq %b expected all 0", go_b, oe_b, pue_b, pde_b, irq_b);
        else n_pass++;
    endtask

    task automatic test_random_regs();
        logic [4:0]  pool [18] = '{R_DIR, R_OUT, R_SET, R_CLR, R_TGL, R_PUE, R_PDE, R_IE, R_IBE,
                                  R_IEV, R_DBE, R_PRE, R_MSKLO, R_MSKHI, R_IS, R_IN, 5'h15, 5'h1F};
        logic [4:0]  a;
        logic [31:0] d, bm, got, exp;
        logic [3:0]  b;
        do_reset();
        m_dir = '0; m_out = '0; m_pue = '0; m_pde = '0; m_ie = '0; m_ibe = '0; m_iev = '0; m_dbe = '0;
        m_pre = 16'd999;
        for (int k = 0; k < 60; k++) begin
            a = pool[$urandom_range(0, 17)];
            d = $urandom;
            b = 4'($urandom);
            bm = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
            case (a)
                R_DIR:   m_dir = (m_dir & ~bm) | (d & bm);
                R_OUT:   m_out = (m_out & ~bm) | (d & bm);
                R_SET:   m_out = m_out | (d & bm);
                R_CLR:   m_out = m_out & ~(d & bm);
                R_TGL:   m_out = m_out ^ (d & bm);
                R_PUE:   m_pue = (m_pue & ~bm) | (d & bm);
                R_PDE:   m_pde = (m_pde & ~bm) | (d & bm);
                R_IE:    m_ie  = (m_ie & ~bm) | (d & bm);
                R_IBE:   m_ibe = (m_ibe & ~bm) | (d & bm);
                R_IEV:   m_iev = (m_iev & ~bm) | (d & bm);
                R_DBE:   m_dbe = (m_dbe & ~bm) | (d & bm);
                R_PRE:   m_pre = (m_pre & ~bm[15:0]) | (d[15:0] & bm[15:0]);
                R_MSKLO: for (int i = 0; i < 16; i++) if (d[16+i]) m_out[i] = d[i];
                R_MSKHI: for (int i = 0; i < 16; i++) if (d[16+i]) m_out[16+i] = d[i];
                default: ;
            endcase
            wr(1'b0, a, d, b);
            rd(1'b0, a, got);
            exp = model_rd(a);
            n_checks++;
            if (got !== exp) $display("FAIL rand_reg[%0h] iter %0d: got %h expected %h", a, k, got, exp);
            else n_pass++;
            n_checks++;
            if ({go_a, oe_a, pue_a, pde_a, irq_a} !== {m_out, m_dir, m_pue, m_pde, 1'b0})
                $display("FAIL rand_outputs iter %0d: got %h/%h/%h/%h irq %b expected %h/%h/%h/%h irq 0",
                         k, go_a, oe_a, pue_a, pde_a, irq_a, m_out, m_dir, m_pue, m_pde);
            else n_pass++;
        end
    endtask

    task automatic test_rise_irq();
        logic [31:0] got;
        do_reset();
        wr(1'b0, R_IE, 32'h8, 4'hF);
        wr(1'b0, R_IEV, 32'h8, 4'hF);
        gpio_a[3] = 1'b1;
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            n_checks++;
            if (irq_a !== (k == S + 1)) $display("FAIL rise_irq clk %0d: got %b expected %b", k, irq_a, k == S + 1);
            else n_pass++;
        end
        rd(1'b0, R_IN, got);
        n_checks++;
        if (got !== 32'h8) $display("FAIL rise_in: got %h expected %h", got, 32'h8);
        else n_pass++;
        wr(1'b0, R_IS, 32'h8, 4'hF);
        n_checks++;
        if (irq_a !== 1'b0) $display("FAIL rise_w1c_irq: got %b expected 0", irq_a);
        else n_pass++;
    endtask

    task automatic test_random_edges();
        localparam int P = 8, L = 64;
        logic [31:0] v [P+L];
        logic [31:0] ie, ibe, iev, ilvl, m_is, t, cur, prv, got;
        bit clr;
        do_reset();
        ie = $urandom; ibe = $urandom; iev = $urandom; ilvl = $urandom;
        wr(1'b0, R_IE, ie, 4'hF);
        wr(1'b0, R_IBE, ibe, 4'hF);
        wr(1'b0, R_IEV, iev, 4'hF);
        wr(1'b0, R_ILVL, ilvl, 4'hF);
        for (int i = 0; i < P; i++) v[i] = '0;
        for (int i = P; i < P + L; i++) v[i] = v[i-1] ^ ($urandom & $urandom);
        m_is = '0;
        for (int n = P; n < P + L; n++) begin
            gpio_a = v[n];
            clr = (n == P) || ($urandom_range(0, 3) == 0);
            if (clr) begin
                adr = R_IS; dat = '1; bs = '1; we = 1'b1; stb_a = 1'b1;
            end
            tick();
            we = 1'b0; stb_a = 1'b0;
            cur = v[n-S];
            prv = v[n-S-1];
            for (int p = 0; p < 32; p++) begin
                if (ilvl[p])     t[p] = iev[p] ? cur[p] : !cur[p];
                else if (ibe[p]) t[p] = cur[p] != prv[p];
                else if (iev[p]) t[p] = cur[p] && !prv[p];
                else             t[p] = !cur[p] && prv[p];
            end
            m_is = (clr ? 32'h0 : m_is) | t;
            rd(1'b0, R_RAW, got);
            n_checks++;
            if (got !== v[n-S+1]) $display("FAIL edges_raw cyc %0d: got %h expected %h", n, got, v[n-S+1]);
            else n_pass++;
            rd(1'b0, R_IS, got);
            n_checks++;
            if (got !== m_is) $display("FAIL edges_is cyc %0d: got %h expected %h", n, got, m_is);
            else n_pass++;
            n_checks++;
            if (irq_a !== |(m_is & ie)) $display("FAIL edges_irq cyc %0d: got %b expected %b", n, irq_a, |(m_is & ie));
            else n_pass++;
        end
    endtask

    task automatic test_debounce();
        logic [31:0] got;
        bit seen;
        do_reset();
        wr(1'b0, R_PRE, 32'h0, 4'b0011);
        wr(1'b0, R_DBE, 32'h1, 4'hF);
        wr(1'b0, R_IE, 32'h1, 4'hF);
        wr(1'b0, R_IEV, 32'h1, 4'hF);
        wr(1'b0, R_IS, 32'hFFFFFFFF, 4'hF);
        seen = 1'b0;
        gpio_a[0] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) gpio_a[0] = 1'b0;
            tick();
            rd(1'b0, R_IN, got);
            if (got[0]) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL dbnc_short_in: got %b expected 0", seen);
        else n_pass++;
        rd(1'b0, R_IS, got);
        n_checks++;
        if (got[0] !== 1'b0) $display("FAIL dbnc_short_is: got %b expected 0", got[0]);
        else n_pass++;
        gpio_a[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            rd(1'b0, R_IN, got);
            if (k == S + 4) begin
                n_checks++;
                if (got[0] !== 1'b0) $display("FAIL dbnc_long_early clk %0d: got %b expected 0", k, got[0]);
                else n_pass++;
            end
            if (k == S + 5) begin
                n_checks++;
                if (got[0] !== 1'b1) $display("FAIL dbnc_long_in clk %0d: got %b expected 1", k, got[0]);
                else n_pass++;
            end
        end
        gpio_a[0] = 1'b0;
        rd(1'b0, R_IS, got);
        n_checks++;
        if ({got[0], irq_a} !== 2'b11) $display("FAIL dbnc_long_is: got is=%b irq=%b expected 1 1", got[0], irq_a);
        else n_pass++;
    endtask

    task automatic test_random_debounce();
        localparam int P = 10, L = 80;
        logic [31:0] v [P+L];
        logic [31:0] dbe, m_filt, exp, got;
        bit all1, all0;
        do_reset();
        wr(1'b0, R_PRE, 32'h0, 4'b0011);
        dbe = $urandom;
        wr(1'b0, R_DBE, dbe, 4'hF);
        for (int i = 0; i < P; i++) v[i] = '0;
        for (int i = P; i < P + L; i++) v[i] = v[i-1] ^ ($urandom & $urandom & $urandom);
        m_filt = '0;
        for (int n = P; n < P + L; n++) begin
            gpio_a = v[n];
            tick();
            for (int p = 0; p < 32; p++) begin
                all1 = 1'b1; all0 = 1'b1;
                for (int j = 1; j <= D; j++) begin
                    if (v[n-S-j][p]) all0 = 1'b0;
                    else             all1 = 1'b0;
                end
                if (all1)      m_filt[p] = 1'b1;
                else if (all0) m_filt[p] = 1'b0;
            end
            exp = (dbe & m_filt) | (~dbe & v[n-S+1]);
            rd(1'b0, R_IN, got);
            n_checks++;
            if (got !== exp) $display("FAIL rdbnc_in cyc %0d: got %h expected %h", n, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_level_low();
        logic [31:0] got;
        do_reset();
        wr(1'b0, R_ILVL, 32'h20, 4'hF);
        wr(1'b0, R_IEV, 32'h0, 4'hF);
        wr(1'b0, R_IE, 32'h20, 4'hF);
        wr(1'b0, R_IS, 32'h20, 4'hF);
        rd(1'b0, R_IS, got);
        n_checks++;
        if ({got, irq_a} !== {32'h20, 1'b1}) $display("FAIL lvl_resets: got is=%h irq=%b expected 20 1", got, irq_a);
        else n_pass++;
        gpio_a[5] = 1'b1;
        repeat (S + 1) tick();
        wr(1'b0, R_IS, 32'h20, 4'hF);
        rd(1'b0, R_IS, got);
        n_checks++;
        if (got !== 32'h0) $display("FAIL lvl_cleared: got %h expected 0", got);
        else n_pass++;
        repeat (2) tick();
        rd(1'b0, R_IS, got);
        n_checks++;
        if ({got, irq_a} !== 33'h0) $display("FAIL lvl_stays_clear: got is=%h irq=%b expected 0 0", got, irq_a);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] got;
        do_reset();
        wr(1'b0, R_IE, 32'h2, 4'hF);
        wr(1'b0, R_IEV, 32'h2, 4'hF);
        gpio_a[1] = 1'b1;
        repeat (S) tick();
        wr(1'b0, R_IS, 32'h2, 4'hF);
        rd(1'b0, R_IS, got);
        n_checks++;
        if (got !== 32'h2) $display("FAIL collide_is: got %h expected %h", got, 32'h2);
        else n_pass++;
        wr(1'b0, R_IS, 32'h2, 4'hF);
        rd(1'b0, R_IS, got);
        n_checks++;
        if (got !== 32'h0) $display("FAIL collide_w1c: got %h expected 0", got);
        else n_pass++;
        wr(1'b0, R_DIR, $urandom | 32'h1, 4'hF);
        wr(1'b0, R_OUT, 32'hA5A5A5A5, 4'hF);
        wr(1'b0, R_PUE, 32'h0F0F0F0F, 4'hF);
        wr(1'b0, R_PDE, 32'hF0F0F0F0, 4'hF);
        wr(1'b0, R_IBE, 32'h10, 4'hF);
        wr(1'b0, R_DBE, 32'h100, 4'hF);
        wr(1'b0, R_PRE, 32'h1234, 4'hF);
        wr(1'b0, R_ILVL, 32'h2, 4'hF);
        tick();
        n_checks++;
        if (irq_a !== 1'b1) $display("FAIL collide_prereset_irq: got %b expected 1", irq_a);
        else n_pass++;
        test_reset();
    endtask

    initial begin
        repeat (2) tick();
        test_reset();
        test_byte_lanes();
        test_atomic();
        test_random_regs();
        test_rise_irq();
        test_random_edges();
        test_debounce();
        test_random_debounce();
        test_level_low();
        test_collision();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gpio_ex.md
GPIO_EX -- requirements
Module: gpio_ex

Interface
REQ-001 Parameter GPIO_WIDTH, default 32; number of pins, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2; input synchroniser depth, legal range 2..4.
REQ-003 Parameter DBNC_SAMPLES, default 4; debounce window in samples, legal range 2..8.
REQ-004 Parameter DBNC_PRE_RST, default 16'd999; reset value of the DBNC_PRE register.
REQ-005 Ports (name, direction, width, meaning) SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- stb_i  in  1  access strobe
- adr_i  in  5  word address
- byte_sel_i  in  4  byte enables
- we_i  in  1  write
- dat_i  in  XLEN  write data
- dat_o  out  XLEN  read data, combinational from adr_i
- gpio_i  in  GPIO_WIDTH  pad input
- gpio_o  out  GPIO_WIDTH  pad output
- gpio_oe_o  out  GPIO_WIDTH  output enable
- gpio_pue_o  out  GPIO_WIDTH  pull-up enable
- gpio_pde_o  out  GPIO_WIDTH  pull-down enable
- irq_o  out  1  interrupt
REQ-006 One clock (clk_i); reset rst_i is synchronous and active-high.

Function
REQ-007 Register map (adr_i):
- 0x00 DIR
- 0x01 OUT
- 0x02 IN (filtered, RO)
- 0x03 SET
- 0x04 CLR
- 0x05 TGL
- 0x06 PUE
- 0x07 PDE
- 0x08 IE
- 0x09 IS (W1C)
- 0x0A IBE
- 0x0B IEV
- 0x0C ILVL
- 0x0D DBE
- 0x0E DBNC_PRE (bits 15:0)
- 0x0F RAW (synchronised, RO)
- 0x10 MSKLO
- 0x11 MSKHI
- other addresses: read 0, writes ignored
REQ-008 Writes SHALL occur only when stb_i && we_i, per byte lane per byte_sel_i; bits at or above GPIO_WIDTH are ignored on write and read as 0.
REQ-009 SET/CLR/TGL SHALL apply OUT|d, OUT&~d, OUT^d per enabled lane; reads of SET/CLR/TGL return OUT.
REQ-010 MSKLO write SHALL update OUT[i] = dat_i[i] for each i in 0..15 where dat_i[16+i]=1; MSKHI does the same for OUT[16+i]; byte_sel_i is ignored; reads return 0.
REQ-011 gpio_i SHALL pass through a SYNC_STAGES-flop synchroniser; its output is RAW.
REQ-012 Prescaler counts 0..DBNC_PRE and asserts tick when count==DBNC_PRE, then wraps to 0; DBNC_PRE=0 gives a tick every cycle; any DBNC_PRE write zeroes the count.
REQ-013 On each tick, every pin SHALL shift RAW into a DBNC_SAMPLES-bit history.
- filt_q[i] becomes 1 on the next clock when the history is all ones.
- filt_q[i] becomes 0 on the next clock when the history is all zeros.
- Otherwise filt_q[i] holds.
REQ-014 IN[i] SHALL equal filt_q[i] when DBE[i]=1, else RAW[i].
REQ-015 Edge detection SHALL compare IN against a registered previous IN; the result is rising, falling or any edge.
REQ-016 Trigger selection:
- ILVL=1, IEV=1: level high (IN=1).
- ILVL=1, IEV=0: level low (IN=0).
- ILVL=0, IBE=1: any edge.
- ILVL=0, IBE=0, IEV=1: rising edge.
- ILVL=0, IBE=0, IEV=0: falling edge.
REQ-017 IS[i] SHALL set on trigger regardless of IE. A trigger and a W1C clear of the same bit in the same cycle leave IS=1. A level trigger re-sets IS on the cycle after a clear while the level persists.
REQ-018 irq_o SHALL equal |(IS & IE), combinationally.
REQ-019 Outputs SHALL be direct: gpio_o=OUT, gpio_oe_o=DIR, gpio_pue_o=PUE, gpio_pde_o=PDE.
REQ-020 Latency with DBE=0: RAW/IN reflect gpio_i after SYNC_STAGES clocks; the edge IS bit follows one clock later.
REQ-021 Latency with DBE=1 and DBNC_PRE=0: IN changes SYNC_STAGES+DBNC_SAMPLES+1 clocks after a stable gpio_i change.
REQ-022 Changing DBE or ILVL MAY create a spurious trigger; software clears IS afterwards, and no suppression is required.

Reset
REQ-023 When rst_i=1 on a clock edge, all registers, synchronisers, histories, filt_q, prev, and the prescaler SHALL clear to 0, except DBNC_PRE, which SHALL load DBNC_PRE_RST.
REQ-024 During reset, all outputs SHALL be 0 and irq_o=0; reset asserted mid-debounce discards the history.

Verification
REQ-025 Byte lanes and masked write:
- Stimulus: write OUT=0xFFFF0000 with byte_sel=4'b0011, then MSKLO=0x00FF00AA.
- Required: gpio_o=0x000000AA.
REQ-026 Atomic operations on GPIO_WIDTH=12:
- Stimulus: write SET=0xFFFFFFFF.
- Required: OUT reads 0x00000FFF.
- Stimulus: then TGL=0x00000F0F.
- Required: OUT reads 0x000000F0.
REQ-027 Rising edge, no debounce:
- Stimulus: IE[3]=1, IEV[3]=1, DBE=0; gpio_i[3] 0->1.
- Required: irq_o=1 exactly SYNC_STAGES+1 clocks after the change.
- Stimulus: W1C IS=0x8.
- Required: irq_o=0.
REQ-028 Debounce filtering (DBNC_PRE=0, DBNC_SAMPLES=4):
- Stimulus: DBE[0]=1; a 3-cycle pulse on gpio_i[0].
- Required: IN[0] stays 0 and IS[0]=0.
- Stimulus: a 10-cycle pulse on gpio_i[0].
- Required: IN[0]=1 at clock SYNC_STAGES+5.
REQ-029 Level-low interrupt:
- Stimulus: ILVL[5]=1, IEV[5]=0, IE[5]=1, gpio_i[5] held 0; W1C IS[5].
- Required: IS[5] reads 1 again the next cycle.
- Stimulus: drive gpio_i[5]=1, then clear IS[5].
- Required: IS[5] stays 0.
REQ-030 Collision and reset:
- Stimulus: an edge trigger coincides with a W1C of the same bit.
- Required: IS bit=1.
- Stimulus: pulse rst_i.
- Required: DBNC_PRE reads 999, and every other register and irq_o read 0.
